nios2_small_oci_ram_arbiter: RTL

Shares the single-port OCI debug monitor RAM between two requesters. The JTAG-side requester is driven from the sysclk debug decode (ocimem take_action path, jdo fields). The CPU-side requester is the Avalon-MM debug slave. The block arbitrates per access, sequences the 1-cycle RAM read latency, and returns read data to the requester that issued the read. It sits between the debug module's sysclk logic and the OCI RAM macro.

---
 rtl/nios2_small_oci_ram_arbiter_if.sv | 46 ++++
 rtl/nios2_small_oci_ram_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/nios2_small_oci_ram_arbiter_if.sv
// Request/response and RAM-side bundle for the OCI debug RAM arbiter.
// slave = arbiter view; master = surrounding debug logic and the RAM macro.
`timescale 1ns/1ps
interface nios2_small_oci_ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              debugack;
  logic              jtag_valid;
  logic              jtag_write;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_wdata;
  logic              jtag_ready;
  logic [31:0]       jtag_rdata;
  logic              jtag_rdata_valid;
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_waitrequest;
  logic [31:0]       cpu_readdata;
  logic              cpu_readdatavalid;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  debugack, jtag_valid, jtag_write, jtag_addr, jtag_wdata,
    input  cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
    input  ram_rdata,
    output jtag_ready, jtag_rdata, jtag_rdata_valid,
    output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
    output ram_addr, ram_wdata, ram_be, ram_we
  );

  modport master (
    output debugack, jtag_valid, jtag_write, jtag_addr, jtag_wdata,
    output cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byteenable,
    output ram_rdata,
    input  jtag_ready, jtag_rdata, jtag_rdata_valid,
    input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
    input  ram_addr, ram_wdata, ram_be, ram_we
  );
endinterface

// File: rtl/nios2_small_oci_ram_arbiter.sv
// Per-access arbiter sharing the single-port OCI debug RAM between the JTAG
// debug decode and the Avalon debug slave; returns read data to its issuer.
`timescale 1ns/1ps
module nios2_small_oci_ram_arbiter #(
  parameter int ADDR_W          = 8,
  parameter bit DEBUG_JTAG_PRIO = 1'b1
) (
  input logic clk,
  input logic reset,
  nios2_small_oci_ram_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state;
  logic   last_cpu;     // 1 = CPU won the most recent grant
  logic   owner_cpu_p1; // issuer of the read being completed in RD_WAIT
  logic   cpu_req;
  logic   grant_jtag;
  logic   grant_cpu;

  // Stage p0: arbitration, only in IDLE
  always_comb begin
    cpu_req    = bus.cpu_read | bus.cpu_write;
    grant_jtag = 1'b0;
    grant_cpu  = 1'b0;
    if (state == IDLE) begin
      if (bus.jtag_valid && cpu_req) begin
        if ((DEBUG_JTAG_PRIO && bus.debugack) || last_cpu)
          grant_jtag = 1'b1;
        else
          grant_cpu = 1'b1;
      end else begin
        grant_jtag = bus.jtag_valid;
        grant_cpu  = cpu_req;
      end
    end
  end

  // RAM port follows the winner; cpu_read&cpu_write together counts as a write
  always_comb begin
    bus.jtag_ready      = grant_jtag;
    bus.cpu_waitrequest = ~grant_cpu;
    bus.ram_addr        = '0;
    bus.ram_wdata       = '0;
    bus.ram_be          = 4'h0;
    bus.ram_we          = 1'b0;
    if (grant_jtag) begin
      bus.ram_addr  = bus.jtag_addr;
      bus.ram_wdata = bus.jtag_wdata;
      bus.ram_be    = 4'hF;
      bus.ram_we    = bus.jtag_write;
    end else if (grant_cpu) begin
      bus.ram_addr  = bus.cpu_address;
      bus.ram_wdata = bus.cpu_writedata;
      bus.ram_be    = bus.cpu_byteenable;
      bus.ram_we    = bus.cpu_write;
    end
  end

  // Stage p1: RD_WAIT captures RAM data; strobe appears the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      last_cpu              <= 1'b1;
      owner_cpu_p1          <= 1'b0;
      bus.jtag_rdata_valid  <= 1'b0;
      bus.cpu_readdatavalid <= 1'b0;
      bus.jtag_rdata        <= '0;
      bus.cpu_readdata      <= '0;
    end else begin
      bus.jtag_rdata_valid  <= 1'b0;
      bus.cpu_readdatavalid <= 1'b0;
      if (state == IDLE) begin
        if (grant_jtag) begin
          last_cpu <= 1'b0;
          if (!bus.jtag_write) begin
            owner_cpu_p1 <= 1'b0;
            state        <= RD_WAIT;
          end
        end else if (grant_cpu) begin
          last_cpu <= 1'b1;
          if (!bus.cpu_write) begin
            owner_cpu_p1 <= 1'b1;
            state        <= RD_WAIT;
          end
        end
      end else begin
        if (owner_cpu_p1) begin
          bus.cpu_readdata      <= bus.ram_rdata;
          bus.cpu_readdatavalid <= 1'b1;
        end else begin
          bus.jtag_rdata       <= bus.ram_rdata;
          bus.jtag_rdata_valid <= 1'b1;
        end
        state <= IDLE;
      end
    end
  end

endmodule
